int_to_float_pipe: RTL and testbench
====================================

// Module: int_to_float_pipe
// PURPOSE
//   Pipelined integer-to-IEEE-754 converter: signed or unsigned IN_W-bit integer -> float (EXP_W/MAN_W),
//   five rounding modes, inexact flag. Successor to the combinational unsigned-only converter.
//   Sits in the FPU issue path (fcvt.s.w / fcvt.s.wu); valid/ready on both sides, 3 stages, 1 result/cycle.
// PARAMETERS
//   IN_W   32  integer input width; legal 8..64, must satisfy IN_W <= 2**(EXP_W-1)
//   EXP_W   8  exponent field width
//   MAN_W  23  stored mantissa (fraction) width; float width FW = 1+EXP_W+MAN_W
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      input transaction valid
//   in_ready   out  1      converter can accept this cycle
//   in_data    in   IN_W   integer operand
//   in_signed  in   1      1: two's-complement operand, 0: unsigned
//   in_rm      in   3      rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  FW     packed float {sign, exp, frac}
//   out_nx     out  1      inexact: discarded bits (guard|sticky) non-zero
// BEHAVIOUR
//   Reset: all stage valids 0; out_valid=0, out_data=0, out_nx=0; in_ready=1 from first cycle after reset.
//   Handshake: transfer when valid&ready. out_data/out_nx held stable while out_valid & !out_ready.
//   Stage i loads when empty or its content moves on the same edge; in_ready = !s1_v | s2 loads.
//   No combinational path out_ready->in_ready beyond this chain; no bubbles under continuous flow.
//   Latency: accept at edge t -> S1 at t, S2 at t+1, S3 at t+2; out_valid high in cycle after edge t+2.
//   S1: sign = in_signed & in_data[IN_W-1]; mag = sign ? -in_data : in_data (IN_W-bit unsigned,
//       so most-negative value gives mag = 2**(IN_W-1)); register sign, mag, rm, zero = (mag==0).
//   S2: lz = leading-zero count of mag; norm = mag << lz (bit IN_W-1 set); e = BIAS + IN_W-1-lz,
//       BIAS = 2**(EXP_W-1)-1. Register sign, norm, e, rm, zero.
//   S3: frac = norm[IN_W-2 -: MAN_W] (zero-padded below if IN_W-1 < MAN_W); guard = next bit below,
//       sticky = OR of all remaining bits; lsb = frac[0].
//       inc: RNE g&(s|lsb); RTZ 0; RDN sign&(g|s); RUP !sign&(g|s); RMM g.
//       frac+inc carries out -> frac=0, e=e+1. nx = g|s. Exponent never overflows under IN_W rule.
//       zero input -> out_data = +0 (all zeros, even if rm=RDN), out_nx = 0.
//   Simultaneous: output pop and input push same cycle both complete; full pipe with out_ready=0
//   holds all three stages and drops in_ready to 0.
//   Reset mid-operation: all in-flight results discarded, no output issued after release.
// STRUCTURE
//   Package fp_cvt_pkg: rounding-mode localparams (RM_RNE..RM_RMM), bias function of EXP_W,
//   float field slicing helpers.
//   Sub-module fp_lzc #(.W(IN_W)): combinational leading-zero counter, output $clog2(W+1) bits,
//   returns W for zero input. Everything else (stage regs, round, pack) stays in this module.
// TESTING (defaults IN_W=32, EXP_W=8, MAN_W=23)
//   unsigned 0x00000001, RNE -> 0x3F800000, nx=0, out_valid 3 edges after accept.
//   signed 0xFFFFFFFF (-1), RNE -> 0xBF800000; signed 0x80000000 -> 0xCF000000, nx=0.
//   unsigned 0xFFFFFFFF: RNE -> 0x4F800000 nx=1 (carry into exponent); RTZ -> 0x4F7FFFFF nx=1.
//   0x01000001 tie case: RNE -> 0x4B800000 nx=1; RUP -> 0x4B800001; RMM -> 0x4B800001;
//     signed 0xFEFFFFFF (-16777217) RDN -> 0xCB800001, RTZ -> 0xCB800000.
//   zero input with each rm -> 0x00000000 nx=0.
//   Back-pressure: 5 back-to-back inputs, out_ready=0 for 6 cycles -> in_ready drops after 3 accepts,
//   out_data stable; release -> 5 results in order, 1/cycle. Assert rst mid-stream -> out_valid=0, none emitted.

Source files
------------

// File: rtl/fp_cvt_pkg.sv
// rtl/fp_cvt_pkg.sv - rounding modes, bias, rounding and packing helpers for int-to-float conversion
package fp_cvt_pkg;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // Exponent bias for an exponent field of exp_w bits.
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Round-increment decision; unknown encodings fall back to round-to-nearest-even.
   function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                      input logic g, input logic s, input logic lsb);
      case (rm)
         RM_RTZ:  return 1'b0;
         RM_RDN:  return sign & (g | s);
         RM_RUP:  return !sign & (g | s);
         RM_RMM:  return g;
         default: return g & (s | lsb);
      endcase
   endfunction

   // Pack {sign, exp, frac} into the low 1+exp_w+man_w bits of a wide word.
   function automatic logic [127:0] fp_pack(input logic sign, input logic [63:0] exp,
                                            input logic [63:0] frac, input int exp_w,
                                            input int man_w);
      logic [127:0] r;
      r = ({127'b0, sign} << (exp_w + man_w)) | ({64'b0, exp} << man_w) | {64'b0, frac};
      return r;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter, returns W for an all-zero input
module fp_lzc #(
   parameter int W = 32,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  data,
   output logic [CW-1:0] count
);

   // Scan upward so the most significant set bit decides the count last.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (data[i]) count = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/int_to_float_pipe.sv
// rtl/int_to_float_pipe.sv - three-stage signed/unsigned integer to IEEE-754 converter with rounding
module int_to_float_pipe
   import fp_cvt_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_W-1:0]          in_data,
   input  logic                     in_signed,
   input  logic [2:0]               in_rm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_data,
   output logic                     out_nx
);

   localparam int FW   = 1 + EXP_W + MAN_W;
   localparam int LZW  = $clog2(IN_W + 1);
   localparam int BIAS = fp_bias(EXP_W);
   // Fraction bits below the hidden one, padded so guard and sticky always exist.
   localparam int TW   = IN_W + MAN_W + 1;

   // Stage 1: sign and magnitude
   logic            s1_v, s1_sign, s1_zero;
   logic [IN_W-1:0] s1_mag;
   logic [2:0]      s1_rm;
   // Stage 2: normalised fraction (hidden bit dropped) and biased exponent
   logic             s2_v, s2_sign, s2_zero;
   logic [IN_W-2:0]  s2_norm;
   logic [EXP_W-1:0] s2_exp;
   logic [2:0]       s2_rm;

   logic s3_load, s2_load, s1_load;

   // A stage may load when empty or when its content leaves on the same edge.
   assign s3_load  = !out_valid | out_ready;
   assign s2_load  = !s2_v | s3_load;
   assign s1_load  = !s1_v | s2_load;
   assign in_ready = s1_load;

   logic            in_sign;
   logic [IN_W-1:0] in_mag;
   assign in_sign = in_signed & in_data[IN_W-1];
   assign in_mag  = in_sign ? -in_data : in_data;

   logic [LZW-1:0] lz;
   fp_lzc #(.W(IN_W)) u_lzc (.data(s1_mag), .count(lz));

   logic [TW-1:0]    tail;
   logic [MAN_W-1:0] frac;
   logic             g, s, inc;
   logic [MAN_W:0]   frac_r;
   logic [EXP_W-1:0] exp_r;
   logic [FW-1:0]    result;
   logic             result_nx;

   assign tail      = {s2_norm, {(MAN_W + 2){1'b0}}};
   assign frac      = tail[TW-1 -: MAN_W];
   assign g         = tail[TW-1-MAN_W];
   assign s         = |tail[TW-2-MAN_W:0];
   assign inc       = round_inc(s2_rm, s2_sign, g, s, frac[0]);
   assign frac_r    = {1'b0, frac} + (MAN_W + 1)'(inc);
   // A carry out of the fraction leaves it all-zero and bumps the exponent.
   assign exp_r     = s2_exp + EXP_W'(frac_r[MAN_W]);
   assign result    = s2_zero ? '0
                    : FW'(fp_pack(s2_sign, 64'(exp_r), 64'(frac_r[MAN_W-1:0]), EXP_W, MAN_W));
   assign result_nx = !s2_zero & (g | s);

   // Stage 1 register: capture sign, magnitude and rounding mode of the accepted operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_mag  <= '0;
         s1_rm   <= RM_RNE;
      end else if (s1_load) begin
         s1_v    <= in_valid;
         s1_sign <= in_sign;
         s1_zero <= (in_mag == '0);
         s1_mag  <= in_mag;
         s1_rm   <= in_rm;
      end
   end

   // Stage 2 register: normalise the magnitude and form the biased exponent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v    <= 1'b0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
         s2_norm <= '0;
         s2_exp  <= '0;
         s2_rm   <= RM_RNE;
      end else if (s2_load) begin
         s2_v    <= s1_v;
         s2_sign <= s1_sign;
         s2_zero <= s1_zero;
         s2_norm <= (IN_W - 1)'(s1_mag << lz);
         s2_exp  <= EXP_W'(BIAS + IN_W - 1) - EXP_W'(lz);
         s2_rm   <= s1_rm;
      end
   end

   // Stage 3 register: rounded, packed result held until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_nx    <= 1'b0;
      end else if (s3_load) begin
         out_valid <= s2_v;
         if (s2_v) begin
            out_data <= result;
            out_nx   <= result_nx;
         end
      end
   end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// tb/tb_int_to_float_pipe.sv - directed self-checking bench for int_to_float_pipe
module tb_int_to_float_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_signed;
   logic [2:0]  in_rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_nx;

   int total = 0;
   int bad   = 0;

   int_to_float_pipe #(.IN_W(32), .EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signed (in_signed),
      .in_rm     (in_rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_nx    (out_nx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated conversion: accept, confirm the 3-edge latency, check the result, pop it.
   task automatic conv(input string tag, input logic [31:0] d, input logic sg, input logic [2:0] rm,
                       input logic [31:0] exp_data, input logic exp_nx);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = sg;
      in_rm     = rm;
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check({tag, "_valid_e1"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      #1 check({tag, "_valid_e2"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_valid_e3"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(exp_data));
      check({tag, "_nx"}, 64'(out_nx), 64'(exp_nx));
      @(posedge clk);
   endtask

   logic [31:0] bp_in  [5];
   logic [31:0] bp_exp [5];
   int          sent, popped, first_pop, last_pop, acc_stall, rst_outs;
   logic [31:0] held;
   logic        have_held;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_signed = 1'b0;
      in_rm     = 3'b000;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_nx", 64'(out_nx), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      conv("u1_rne",     32'h00000001, 1'b0, 3'b000, 32'h3F800000, 1'b0);
      conv("sm1_rne",    32'hFFFFFFFF, 1'b1, 3'b000, 32'hBF800000, 1'b0);
      conv("smin_rne",   32'h80000000, 1'b1, 3'b000, 32'hCF000000, 1'b0);
      conv("umax_rne",   32'hFFFFFFFF, 1'b0, 3'b000, 32'h4F800000, 1'b1);
      conv("umax_rtz",   32'hFFFFFFFF, 1'b0, 3'b001, 32'h4F7FFFFF, 1'b1);
      conv("tie_rne",    32'h01000001, 1'b0, 3'b000, 32'h4B800000, 1'b1);
      conv("tie_rup",    32'h01000001, 1'b0, 3'b011, 32'h4B800001, 1'b1);
      conv("tie_rmm",    32'h01000001, 1'b0, 3'b100, 32'h4B800001, 1'b1);
      conv("tie_rm7",    32'h01000001, 1'b0, 3'b111, 32'h4B800000, 1'b1);
      conv("ntie_rdn",   32'hFEFFFFFF, 1'b1, 3'b010, 32'hCB800001, 1'b1);
      conv("ntie_rtz",   32'hFEFFFFFF, 1'b1, 3'b001, 32'hCB800000, 1'b1);
      conv("ntie_rup",   32'hFEFFFFFF, 1'b1, 3'b011, 32'hCB800000, 1'b1);
      conv("u3_exact",   32'h00000003, 1'b0, 3'b000, 32'h40400000, 1'b0);
      conv("s_pos_big",  32'h7FFFFFFF, 1'b1, 3'b001, 32'h4EFFFFFF, 1'b1);
      conv("zero_rne",   32'h00000000, 1'b0, 3'b000, 32'h00000000, 1'b0);
      conv("zero_rtz",   32'h00000000, 1'b1, 3'b001, 32'h00000000, 1'b0);
      conv("zero_rdn",   32'h00000000, 1'b1, 3'b010, 32'h00000000, 1'b0);
      conv("zero_rup",   32'h00000000, 1'b0, 3'b011, 32'h00000000, 1'b0);
      conv("zero_rmm",   32'h00000000, 1'b0, 3'b100, 32'h00000000, 1'b0);

      // Back-pressure: five back-to-back inputs, consumer stalled for the first six cycles.
      bp_in  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
      bp_exp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      sent = 0; popped = 0; first_pop = -1; last_pop = -1; acc_stall = 0; have_held = 1'b0;
      held = '0;
      @(negedge clk);
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = (cyc >= 6);
         in_valid  = (sent < 5);
         in_data   = (sent < 5) ? bp_in[sent] : 32'd0;
         in_signed = 1'b0;
         in_rm     = 3'b000;
         #1;
         if (cyc == 3) check("bp_in_ready_drop", 64'(in_ready), 64'd0);
         if (!out_ready && out_valid) begin
            if (!have_held) begin
               held      = out_data;
               have_held = 1'b1;
            end else begin
               check("bp_hold_data", 64'(out_data), 64'(held));
            end
         end
         if (out_valid && out_ready) begin
            if (popped < 5) check("bp_result", 64'(out_data), 64'(bp_exp[popped]));
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            popped++;
         end
         if (in_valid && in_ready) begin
            sent++;
            if (cyc < 6) acc_stall++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp_accepts_while_stalled", 64'(acc_stall), 64'd3);
      check("bp_sent", 64'(sent), 64'd5);
      check("bp_popped", 64'(popped), 64'd5);
      check("bp_pop_span", 64'(last_pop - first_pop), 64'd4);
      check("bp_first_pop", 64'(first_pop), 64'd6);

      // Reset in the middle of traffic: nothing may emerge afterwards.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'd7;
      @(negedge clk);
      in_data   = 32'd9;
      @(negedge clk);
      in_valid  = 1'b0;
      rst       = 1'b1;
      #1 check("midrst_out_valid", 64'(out_valid), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rst_outs = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) rst_outs++;
      end
      check("midrst_no_output", 64'(rst_outs), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      conv("post_rst_u5", 32'h00000005, 1'b0, 3'b000, 32'h40A00000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
